// File: rtl/grf.sv
// General-purpose register file: 32 x 32-bit, two async read ports,
// one synchronous write port, $0 hardwired to zero.
module grf (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [4:0]  RegAddr,
    input  logic [31:0] RegData,
    input  logic [31:0] pc,
    output logic [31:0] RD1,
    output logic [31:0] RD2
);

    logic [31:0] regs [32];
    logic        wr_en;

    assign wr_en = RegWrite && (RegAddr != 5'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0000_0000;
            end
        end else if (wr_en) begin
            regs[RegAddr] <= RegData;
        end
    end

    // Gating on address zero keeps $0 reading 0 regardless of regs[0].
    assign RD1 = (A1 == 5'd0) ? 32'h0000_0000 : regs[A1];
    assign RD2 = (A2 == 5'd0) ? 32'h0000_0000 : regs[A2];

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset && wr_en) begin
            $display("@%h: $%d <= %h", pc, RegAddr, RegData);
        end
    end
`endif

endmodule

// File: tb/tb_grf.sv
// Directed self-checking bench for grf.
// Inputs change on negedge; outputs sampled away from posedge.
module tb_grf;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [4:0]  RegAddr;
    logic [31:0] RegData;
    logic [31:0] pc;
    logic [31:0] RD1;
    logic [31:0] RD2;

    int total = 0;
    int bad = 0;

    grf dut (
        .clk(clk),
        .reset(reset),
        .RegWrite(RegWrite),
        .A1(A1),
        .A2(A2),
        .RegAddr(RegAddr),
        .RegData(RegData),
        .pc(pc),
        .RD1(RD1),
        .RD2(RD2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        RegWrite = 1'b1;
        RegAddr  = a;
        RegData  = d;
        pc       = pc + 32'd4;
        @(posedge clk);
        #1;
        @(negedge clk);
        RegWrite = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            A1 = i[4:0];
            A2 = 5'(31 - i);
            #1;
            chk({tag, "_rd1"}, RD1, 32'h0);
            chk({tag, "_rd2"}, RD2, 32'h0);
        end
    endtask

    initial begin
        reset    = 1'b0;
        RegWrite = 1'b0;
        A1       = 5'd0;
        A2       = 5'd1;
        RegAddr  = 5'd0;
        RegData  = 32'h0;
        pc       = 32'h0000_3000;

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        check_all_zero("reset");

        // Disabled write
        A2       = 5'd1;
        RegAddr  = 5'd1;
        RegData  = 32'hffff_ffff;
        RegWrite = 1'b0;
        @(posedge clk);
        #1;
        chk("dis_wr", RD2, 32'h0);

        // Enabled write, old value before edge
        @(negedge clk);
        RegWrite = 1'b1;
        #1;
        chk("en_wr_pre", RD2, 32'h0);
        @(posedge clk);
        #1;
        chk("en_wr_post", RD2, 32'hffff_ffff);
        @(negedge clk);
        RegWrite = 1'b0;

        // $0 protection
        A1 = 5'd0;
        A2 = 5'd1;
        write_reg(5'd0, 32'hffff_ffff);
        chk("zero_rd1", RD1, 32'h0);
        chk("zero_keep1", RD2, 32'hffff_ffff);

        // X on address/data with write disabled
        RegAddr = 5'bx;
        RegData = 32'hx;
        @(posedge clk);
        #1;
        chk("x_idle", RD2, 32'hffff_ffff);

        // Full sweep
        for (int i = 1; i < 32; i++) begin
            write_reg(i[4:0], 32'h1000_0000 + i);
        end
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 32; j++) begin
                A1 = i[4:0];
                A2 = j[4:0];
                #1;
                chk("sweep_rd1", RD1, (i == 0) ? 32'h0 : 32'h1000_0000 + i);
                chk("sweep_rd2", RD2, (j == 0) ? 32'h0 : 32'h1000_0000 + j);
            end
        end

        // Async reset between edges
        @(posedge clk);
        #3;
        reset = 1'b0;
        A1 = 5'd31;
        A2 = 5'd1;
        #1;
        chk("async_rst1", RD1, 32'h0);
        chk("async_rst2", RD2, 32'h0);
        check_all_zero("async_rst");

        // Write attempted while reset held: reset wins
        @(negedge clk);
        RegWrite = 1'b1;
        RegAddr  = 5'd3;
        RegData  = 32'haaaa_5555;
        A1       = 5'd3;
        @(posedge clk);
        #1;
        chk("rst_wins", RD1, 32'h0);
        @(negedge clk);
        RegWrite = 1'b0;
        reset    = 1'b1;

        // Write then reset mid-cycle loses it
        A1 = 5'd7;
        write_reg(5'd7, 32'h7777_7777);
        chk("pre_lost", RD1, 32'h7777_7777);
        reset = 1'b0;
        #1;
        chk("lost_wr", RD1, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Same-address read/write
        A1 = 5'd5;
        A2 = 5'd5;
        write_reg(5'd5, 32'h1234_5678);
        RegAddr  = 5'd5;
        RegData  = 32'hdead_beef;
        RegWrite = 1'b1;
        #1;
        chk("same_pre1", RD1, 32'h1234_5678);
        chk("same_pre2", RD2, 32'h1234_5678);
        @(posedge clk);
        #1;
        chk("same_post1", RD1, 32'hdead_beef);
        chk("same_post2", RD2, 32'hdead_beef);
        @(negedge clk);
        RegWrite = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
